cov_acc: RTL and testbench

- Upstream feeder of the 2x2 eigen-decomposition stage in the unitary-ESPRIT DoA chain.
- Takes the real-valued transformed samples of two antenna channels, y1 and y2.
- Accumulates y1*y1, y2*y2 and y1*y2 over a window of 2^ACC_LOG valid samples.
- At the end of each window it emits the averaged covariance terms r11, r22 and r12, cast to the eigen stage input format, with a one-cycle valid pulse.

---
 rtl/cov_acc.sv | 149 ++++++++++++++
 tb/tb_cov_acc.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cov_acc.sv
// Windowed 2x2 covariance accumulator: averages y1*y1, y2*y2 and y1*y2 over
// 2^ACC_LOG valid samples and casts the means to the eigen-stage format.
`timescale 1ns/1ps
module cov_acc #(
   parameter int DIN_WIDTH  = 16,
   parameter int DIN_POINT  = 15,
   parameter int ACC_LOG    = 10,
   parameter int DOUT_WIDTH = 16,
   parameter int DOUT_POINT = 15
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic signed [DIN_WIDTH-1:0]  y1,
   input  logic signed [DIN_WIDTH-1:0]  y2,
   input  logic                         din_valid,
   input  logic                         sync,
   output logic [DOUT_WIDTH-1:0]        r11,
   output logic [DOUT_WIDTH-1:0]        r22,
   output logic [DOUT_WIDTH-1:0]        r12,
   output logic                         dout_valid
);

   localparam int PW = 2*DIN_WIDTH;
   localparam int AW = PW + ACC_LOG;
   // Averaging and fractional-bit drop fold into one arithmetic shift (floor).
   localparam int SH = ACC_LOG + 2*DIN_POINT - DOUT_POINT;
   localparam logic signed [AW-1:0] OUT_MAX = {{(AW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
   localparam logic signed [AW-1:0] OUT_MIN = {{(AW-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

   function automatic logic [DOUT_WIDTH-1:0] sat_cast(input logic signed [AW-1:0] d,
                                                      input logic non_neg);
      logic signed [AW-1:0] s;
      s = d >>> SH;
      if (s > OUT_MAX)
         return OUT_MAX[DOUT_WIDTH-1:0];
      else if (non_neg && s[AW-1])
         return '0;
      else if (s < OUT_MIN)
         return OUT_MIN[DOUT_WIDTH-1:0];
      else
         return s[DOUT_WIDTH-1:0];
   endfunction

   logic signed [DIN_WIDTH-1:0] y1_p1, y2_p1;
   logic                        vld_p1, sync_p1;
   logic signed [PW-1:0]        p11_p2, p22_p2, p12_p2;
   logic                        vld_p2, sync_p2;
   logic signed [AW-1:0]        acc11, acc22, acc12;
   logic [ACC_LOG-1:0]          cnt;
   logic signed [AW-1:0]        dump11_p3, dump22_p3, dump12_p3;
   logic                        vld_p3;
   logic signed [AW-1:0]        e11, e22, e12;
   logic signed [AW-1:0]        s11, s22, s12;

   assign e11 = AW'(p11_p2);
   assign e22 = AW'(p22_p2);
   assign e12 = AW'(p12_p2);
   assign s11 = acc11 + e11;
   assign s22 = acc22 + e22;
   assign s12 = acc12 + e12;

   // Stage 1: input register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y1_p1   <= '0;
         y2_p1   <= '0;
         vld_p1  <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         y1_p1   <= y1;
         y2_p1   <= y2;
         vld_p1  <= din_valid;
         sync_p1 <= sync;
      end
   end

   // Stage 2: full-precision products
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p11_p2  <= '0;
         p22_p2  <= '0;
         p12_p2  <= '0;
         vld_p2  <= 1'b0;
         sync_p2 <= 1'b0;
      end else begin
         p11_p2  <= y1_p1 * y1_p1;
         p22_p2  <= y2_p1 * y2_p1;
         p12_p2  <= y1_p1 * y2_p1;
         vld_p2  <= vld_p1;
         sync_p2 <= sync_p1;
      end
   end

   // Stage 3: accumulate; sync takes priority over a window-end dump
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc11     <= '0;
         acc22     <= '0;
         acc12     <= '0;
         cnt       <= '0;
         dump11_p3 <= '0;
         dump22_p3 <= '0;
         dump12_p3 <= '0;
         vld_p3    <= 1'b0;
      end else begin
         vld_p3 <= 1'b0;
         if (sync_p2) begin
            acc11 <= vld_p2 ? e11 : '0;
            acc22 <= vld_p2 ? e22 : '0;
            acc12 <= vld_p2 ? e12 : '0;
            cnt   <= vld_p2 ? ACC_LOG'(1) : '0;
         end else if (vld_p2) begin
            if (cnt == '1) begin
               dump11_p3 <= s11;
               dump22_p3 <= s22;
               dump12_p3 <= s12;
               vld_p3    <= 1'b1;
               acc11     <= '0;
               acc22     <= '0;
               acc12     <= '0;
               cnt       <= '0;
            end else begin
               acc11 <= s11;
               acc22 <= s22;
               acc12 <= s12;
               cnt   <= cnt + 1'b1;
            end
         end
      end
   end

   // Stage 4: averaged, truncated and saturated outputs, held between pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r11        <= '0;
         r22        <= '0;
         r12        <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= vld_p3;
         if (vld_p3) begin
            r11 <= sat_cast(dump11_p3, 1'b1);
            r22 <= sat_cast(dump22_p3, 1'b1);
            r12 <= sat_cast(dump12_p3, 1'b0);
         end
      end
   end

endmodule

// File: tb/tb_cov_acc.sv
// Directed bench for cov_acc with a 4-sample window: pulse timing, values,
// saturation, gaps, sync restarts and asynchronous reset.
`timescale 1ns/1ps
module tb_cov_acc;

   logic               clk = 1'b0;
   logic               rst_n;
   logic signed [15:0] y1, y2;
   logic               din_valid, sync;
   logic [15:0]        r11, r22, r12;
   logic               dout_valid;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int cap = 0;
   int vcap = 0;
   int base = 0;
   int gapn = 0;

   int          pc[$];
   logic [15:0] q11[$], q22[$], q12[$];

   cov_acc #(
      .DIN_WIDTH (16),
      .DIN_POINT (15),
      .ACC_LOG   (2),
      .DOUT_WIDTH(16),
      .DOUT_POINT(15)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .y1        (y1),
      .y2        (y2),
      .din_valid (din_valid),
      .sync      (sync),
      .r11       (r11),
      .r22       (r22),
      .r12       (r12),
      .dout_valid(dout_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse recorder: edge index and output values of every dout_valid pulse
   always @(negedge clk) begin
      if (dout_valid) begin
         pc.push_back(cyc);
         q11.push_back(r11);
         q22.push_back(r22);
         q12.push_back(r12);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one input cycle; cap holds the index of the capturing edge.
   task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic v, input logic s);
      y1 = a;
      y2 = b;
      din_valid = v;
      sync = s;
      @(posedge clk);
      #1;
      cap = cyc;
      y1 = 16'($urandom);
      y2 = 16'($urandom);
      din_valid = 1'b0;
      sync = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(16'($urandom), 16'($urandom), 1'b0, 1'b0);
   endtask

   task automatic check_one(input string tag, input int b, input int t,
                            input logic [15:0] e11, input logic [15:0] e22, input logic [15:0] e12);
      check({tag, "_count"}, 32'(pc.size() - b), 32'd1);
      if (pc.size() > b) begin
         check({tag, "_time"}, 32'(pc[b]), 32'(t + 3));
         check({tag, "_r11"}, 32'(q11[b]), 32'(e11));
         check({tag, "_r22"}, 32'(q22[b]), 32'(e22));
         check({tag, "_r12"}, 32'(q12[b]), 32'(e12));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      y1 = '0;
      y2 = '0;
      din_valid = 1'b0;
      sync = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_r11", 32'(r11), 32'h0);
      check("rst_r22", 32'(r22), 32'h0);
      check("rst_r12", 32'(r12), 32'h0);
      check("rst_vld", 32'(dout_valid), 32'h0);
      #3 rst_n = 1'b1;
      idle(2);

      // basic window
      base = pc.size();
      repeat (4) drive(16'h4000, 16'h2000, 1'b1, 1'b0);
      vcap = cap;
      idle(8);
      check_one("basic", base, vcap, 16'h2000, 16'h0800, 16'h1000);

      // negative cross term, back-to-back windows
      base = pc.size();
      repeat (8) drive(16'h4000, 16'hE000, 1'b1, 1'b0);
      vcap = cap;
      idle(8);
      check("b2b_count", 32'(pc.size() - base), 32'd2);
      if (pc.size() >= base + 2) begin
         check("b2b_spacing", 32'(pc[base+1] - pc[base]), 32'd4);
         check("b2b_time", 32'(pc[base+1]), 32'(vcap + 3));
         check("b2b_r12_a", 32'(q12[base]), 32'hF000);
         check("b2b_r12_b", 32'(q12[base+1]), 32'hF000);
         check("b2b_r22_a", 32'(q22[base]), 32'h0800);
         check("b2b_r22_b", 32'(q22[base+1]), 32'h0800);
         check("b2b_r11_b", 32'(q11[base+1]), 32'h2000);
      end

      // positive saturation from (-1)*(-1)
      base = pc.size();
      repeat (4) drive(16'h8000, 16'h8000, 1'b1, 1'b0);
      vcap = cap;
      idle(8);
      check_one("satpos", base, vcap, 16'h7FFF, 16'h7FFF, 16'h7FFF);

      // floor truncation of tiny values
      base = pc.size();
      repeat (4) drive(16'h0001, 16'h8000, 1'b1, 1'b0);
      vcap = cap;
      idle(8);
      check_one("trunc", base, vcap, 16'h0000, 16'h7FFF, 16'hFFFF);

      // gapped valid with garbage data in the gaps
      base = pc.size();
      for (int i = 0; i < 4; i++) begin
         drive(16'h4000, 16'h2000, 1'b1, 1'b0);
         vcap = cap;
         gapn = $urandom_range(1, 3);
         idle(gapn);
      end
      idle(8);
      check_one("gap", base, vcap, 16'h2000, 16'h0800, 16'h1000);

      // sync mid-window discards the partial window
      base = pc.size();
      repeat (2) drive(16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
      drive(16'h4000, 16'h2000, 1'b1, 1'b1);
      repeat (3) drive(16'h4000, 16'h2000, 1'b1, 1'b0);
      vcap = cap;
      idle(8);
      check_one("syncmid", base, vcap, 16'h2000, 16'h0800, 16'h1000);

      // sync on the window-end sample: that sample opens the new window
      base = pc.size();
      repeat (3) drive(16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
      drive(16'h4000, 16'h2000, 1'b1, 1'b1);
      repeat (3) drive(16'h4000, 16'h2000, 1'b1, 1'b0);
      vcap = cap;
      idle(8);
      check_one("syncend", base, vcap, 16'h2000, 16'h0800, 16'h1000);

      // asynchronous reset mid-window
      base = pc.size();
      repeat (2) drive(16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_r11", 32'(r11), 32'h0);
      check("arst_r22", 32'(r22), 32'h0);
      check("arst_r12", 32'(r12), 32'h0);
      check("arst_vld", 32'(dout_valid), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #4 rst_n = 1'b1;
      repeat (4) drive(16'h4000, 16'h2000, 1'b1, 1'b0);
      vcap = cap;
      idle(8);
      check_one("postrst", base, vcap, 16'h2000, 16'h0800, 16'h1000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
